// File: rtl/lease_cache_pkg.sv
// rtl/lease_cache_pkg.sv - shared loader FSM state type and lease block stride helper
package lease_cache_pkg;

  typedef enum logic [2:0] {
    IDLE,
    HDR_REQ,
    HDR_WAIT,
    REF_REQ,
    REF_WAIT,
    LSE_REQ,
    LSE_WAIT,
    DONE
  } loader_state_e;

  // Words per phase block: one header word, N ref addresses, N leases.
  function automatic logic [31:0] phase_stride(input logic [31:0] n_entries);
    return (n_entries << 1) + 32'd1;
  endfunction

endpackage

// File: rtl/lease_loader_addr_gen.sv
// rtl/lease_loader_addr_gen.sv - registered byte address of a phase's lease block
module lease_loader_addr_gen
  import lease_cache_pkg::*;
#(
  parameter int N_ENTRIES = 128,
  parameter int BW_PHASE  = 8
) (
  input  logic                clock_i,
  input  logic                resetn_i,
  input  logic                load_i,
  input  logic [BW_PHASE-1:0] phase_i,
  input  logic [31:0]         base_addr_i,
  output logic [31:0]         block_addr_o
);

  localparam logic [31:0] PHASE_STRIDE = phase_stride(32'(N_ENTRIES));

  logic [31:0] w_stride_bytes;
  logic [31:0] w_block_addr;
  logic [31:0] r_block_addr;

  // Wraps modulo 2^32 by construction; oversize phases are not flagged.
  assign w_stride_bytes = PHASE_STRIDE << 2;
  assign w_block_addr   = base_addr_i + w_stride_bytes * 32'(phase_i);

  always_ff @(posedge clock_i or negedge resetn_i) begin
    if (!resetn_i) begin
      r_block_addr <= '0;
    end else if (load_i) begin
      r_block_addr <= w_block_addr;
    end
  end

  assign block_addr_o = r_block_addr;

endmodule

// File: rtl/lease_table_loader.sv
// rtl/lease_table_loader.sv - fetches a phase's ref/lease block from memory into the LLT
// Optional LEASE_LOADER_STATS_EN adds load_cycles_o (cycles of the last load).
module lease_table_loader
  import lease_cache_pkg::*;
#(
  parameter int N_ENTRIES = 128,
  parameter int BW_PHASE  = 8
) (
  input  logic                         clock_i,
  input  logic                         resetn_i,
  input  logic                         phase_change_i,
  input  logic [BW_PHASE-1:0]          phase_i,
  input  logic [31:0]                  base_addr_i,
  output logic                         mem_req_o,
  output logic [31:0]                  mem_addr_o,
  input  logic                         mem_ack_i,
  input  logic [31:0]                  mem_data_i,
  output logic [$clog2(N_ENTRIES):0]   llt_addr_o,
  output logic                         llt_wren_o,
  output logic [31:0]                  llt_data_o,
  output logic [$clog2(N_ENTRIES)-1:0] phase_refs_o,
  output logic                         busy_o,
  output logic                         done_o,
  output logic                         overflow_o
`ifdef LEASE_LOADER_STATS_EN
  ,
  output logic [31:0]                  load_cycles_o
`endif
);

  localparam int          BW_ENTRIES = $clog2(N_ENTRIES);
  localparam logic [31:0] MAX_REFS   = 32'(N_ENTRIES - 1);

  loader_state_e         r_state;
  logic [BW_ENTRIES-1:0] r_idx;
  logic [BW_ENTRIES-1:0] r_refs;
  logic                  r_overflow;
  logic                  r_pend;
  logic [BW_PHASE-1:0]   r_pend_phase;

  logic                  w_start;
  logic [BW_PHASE-1:0]   w_start_phase;
  logic [31:0]           w_block_addr;
  logic [31:0]           w_idx32;
  logic [31:0]           w_word_off;
  logic                  w_in_read;
  logic                  w_wr;

  assign w_start       = (r_state == IDLE) && (phase_change_i || r_pend);
  assign w_start_phase = phase_change_i ? phase_i : r_pend_phase;

  lease_loader_addr_gen #(
    .N_ENTRIES (N_ENTRIES),
    .BW_PHASE  (BW_PHASE)
  ) u_addr_gen (
    .clock_i      (clock_i),
    .resetn_i     (resetn_i),
    .load_i       (w_start),
    .phase_i      (w_start_phase),
    .base_addr_i  (base_addr_i),
    .block_addr_o (w_block_addr)
  );

  assign w_idx32 = 32'(r_idx);

  always_comb begin
    w_word_off = 32'd0;
    case (r_state)
      REF_REQ, REF_WAIT: w_word_off = 32'd1 + w_idx32;
      LSE_REQ, LSE_WAIT: w_word_off = 32'(N_ENTRIES) + 32'd1 + w_idx32;
      default:           w_word_off = 32'd0;
    endcase
  end

  // Address is decoded from registered state/index, so it holds steady through each WAIT.
  assign w_in_read  = r_state inside {HDR_REQ, HDR_WAIT, REF_REQ, REF_WAIT, LSE_REQ, LSE_WAIT};
  assign mem_addr_o = w_in_read ? (w_block_addr + (w_word_off << 2)) : 32'd0;
  assign mem_req_o  = r_state inside {HDR_REQ, REF_REQ, LSE_REQ};

  assign w_wr       = mem_ack_i && ((r_state == REF_WAIT) || (r_state == LSE_WAIT));
  assign llt_wren_o = w_wr;
  assign llt_addr_o = w_wr ? {(r_state == LSE_WAIT), r_idx} : '0;
  assign llt_data_o = w_wr ? mem_data_i : 32'd0;

  assign busy_o       = (r_state != IDLE);
  assign done_o       = (r_state == DONE);
  assign phase_refs_o = r_refs;
  assign overflow_o   = r_overflow;

  always_ff @(posedge clock_i or negedge resetn_i) begin
    if (!resetn_i) begin
      r_state      <= IDLE;
      r_idx        <= '0;
      r_refs       <= '0;
      r_overflow   <= 1'b0;
      r_pend       <= 1'b0;
      r_pend_phase <= '0;
    end else begin
      // Requests arriving mid-load (including DONE) collapse into one pending slot.
      if ((r_state != IDLE) && phase_change_i) begin
        r_pend       <= 1'b1;
        r_pend_phase <= phase_i;
      end
      case (r_state)
        IDLE: begin
          if (w_start) begin
            r_state <= HDR_REQ;
            r_pend  <= 1'b0;
          end
        end
        HDR_REQ: r_state <= HDR_WAIT;
        HDR_WAIT: begin
          if (mem_ack_i) begin
            if (mem_data_i > MAX_REFS) begin
              r_refs     <= MAX_REFS[BW_ENTRIES-1:0];
              r_overflow <= 1'b1;
            end else begin
              r_refs <= mem_data_i[BW_ENTRIES-1:0];
            end
            r_idx   <= '0;
            r_state <= REF_REQ;
          end
        end
        REF_REQ: r_state <= REF_WAIT;
        REF_WAIT: begin
          if (mem_ack_i) begin
            if (w_idx32 == MAX_REFS) begin
              r_idx   <= '0;
              r_state <= (r_refs == '0) ? DONE : LSE_REQ;
            end else begin
              r_idx   <= r_idx + BW_ENTRIES'(1);
              r_state <= REF_REQ;
            end
          end
        end
        LSE_REQ: r_state <= LSE_WAIT;
        LSE_WAIT: begin
          if (mem_ack_i) begin
            if ((w_idx32 + 32'd1) >= 32'(r_refs)) begin
              r_idx   <= '0;
              r_state <= DONE;
            end else begin
              r_idx   <= r_idx + BW_ENTRIES'(1);
              r_state <= LSE_REQ;
            end
          end
        end
        DONE:    r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
    end
  end

`ifdef LEASE_LOADER_STATS_EN
  logic [31:0] r_cycles;
  logic [31:0] r_load_cycles;

  always_ff @(posedge clock_i or negedge resetn_i) begin
    if (!resetn_i) begin
      r_cycles      <= '0;
      r_load_cycles <= '0;
    end else begin
      if (w_start) begin
        r_cycles <= '0;
      end else if ((r_state != IDLE) && (r_state != DONE)) begin
        r_cycles <= r_cycles + 32'd1;
      end
      if (r_state == DONE) begin
        r_load_cycles <= r_cycles;
      end
    end
  end

  assign load_cycles_o = r_load_cycles;
`endif

endmodule

// File: tb/tb_lease_table_loader.sv
// tb/tb_lease_table_loader.sv - scoreboard bench for lease_table_loader (N_ENTRIES=4)
module tb_lease_table_loader;

  localparam int N   = 4;
  localparam int LAT = 3;

  logic        clock_i = 1'b0;
  logic        resetn_i = 1'b0;
  logic        phase_change_i = 1'b0;
  logic [7:0]  phase_i = 8'd0;
  logic [31:0] base_addr_i = 32'h1000;
  logic        mem_req_o;
  logic [31:0] mem_addr_o;
  logic        mem_ack_i = 1'b0;
  logic [31:0] mem_data_i = 32'd0;
  logic [2:0]  llt_addr_o;
  logic        llt_wren_o;
  logic [31:0] llt_data_o;
  logic [1:0]  phase_refs_o;
  logic        busy_o;
  logic        done_o;
  logic        overflow_o;
`ifdef LEASE_LOADER_STATS_EN
  logic [31:0] load_cycles_o;
`endif

  lease_table_loader #(.N_ENTRIES(N), .BW_PHASE(8)) dut (
    .clock_i        (clock_i),
    .resetn_i       (resetn_i),
    .phase_change_i (phase_change_i),
    .phase_i        (phase_i),
    .base_addr_i    (base_addr_i),
    .mem_req_o      (mem_req_o),
    .mem_addr_o     (mem_addr_o),
    .mem_ack_i      (mem_ack_i),
    .mem_data_i     (mem_data_i),
    .llt_addr_o     (llt_addr_o),
    .llt_wren_o     (llt_wren_o),
    .llt_data_o     (llt_data_o),
    .phase_refs_o   (phase_refs_o),
    .busy_o         (busy_o),
    .done_o         (done_o),
    .overflow_o     (overflow_o)
`ifdef LEASE_LOADER_STATS_EN
    ,
    .load_cycles_o  (load_cycles_o)
`endif
  );

  always #5 clock_i = ~clock_i;

  int n_checks = 0;
  int n_errors = 0;
  int done_cnt = 0;
  int ref_wr = 0;
  int lse_wr = 0;

  logic [31:0] hdr [logic [31:0]];
  logic [31:0] exp_rd [$];
  logic [34:0] exp_wr [$];

  function automatic logic [31:0] blk(input int p);
    return 32'h1000 + 32'(36 * p);
  endfunction

  function automatic logic [31:0] mem_rd(input logic [31:0] a);
    if (hdr.exists(a)) return hdr[a];
    return a ^ 32'h5A5A_0000;
  endfunction

  function automatic void expect_load(input int p);
    logic [31:0] b;
    int refs;
    b = blk(p);
    refs = (hdr[b] > 32'(N - 1)) ? N - 1 : int'(hdr[b]);
    exp_rd.push_back(b);
    for (int i = 0; i < N; i++) begin
      exp_rd.push_back(b + 32'(4 + 4 * i));
      exp_wr.push_back({1'b0, 2'(i), mem_rd(b + 32'(4 + 4 * i))});
    end
    for (int i = 0; i < refs; i++) begin
      exp_rd.push_back(b + 32'(4 * (N + 1 + i)));
      exp_wr.push_back({1'b1, 2'(i), mem_rd(b + 32'(4 * (N + 1 + i)))});
    end
  endfunction

  // Memory model: ack lands LAT cycles after the request cycle.
  int          lat_cnt = 0;
  logic [31:0] lat_addr = 32'd0;
  always @(posedge clock_i) begin
    #1;
    mem_ack_i = 1'b0;
    if (mem_req_o) begin
      lat_cnt  = LAT;
      lat_addr = mem_addr_o;
    end else if (lat_cnt > 0) begin
      lat_cnt--;
      if (lat_cnt == 0) begin
        mem_ack_i  = 1'b1;
        mem_data_i = mem_rd(lat_addr);
      end
    end
  end

  logic [31:0] out_addr = 32'd0;
  bit          out_valid = 1'b0;
  always @(negedge clock_i) begin
    logic [31:0] er;
    logic [34:0] ew;
    if (!resetn_i) out_valid = 1'b0;
    if (mem_req_o) begin
      n_checks++;
      if (exp_rd.size() == 0) begin
        n_errors++;
        $display("FAIL read_addr: unexpected read at %h, none expected", mem_addr_o);
      end else begin
        er = exp_rd.pop_front();
        if (mem_addr_o !== er) begin
          n_errors++;
          $display("FAIL read_addr: got %h, expected %h", mem_addr_o, er);
        end
      end
      out_addr  = mem_addr_o;
      out_valid = 1'b1;
    end
    if (mem_ack_i && out_valid && busy_o) begin
      n_checks++;
      if (mem_addr_o !== out_addr) begin
        n_errors++;
        $display("FAIL addr_stable: got %h, expected %h", mem_addr_o, out_addr);
      end
      out_valid = 1'b0;
    end
    if (llt_wren_o) begin
      n_checks++;
      if (llt_addr_o[2]) lse_wr++; else ref_wr++;
      if (exp_wr.size() == 0) begin
        n_errors++;
        $display("FAIL llt_write: unexpected write addr %h data %h", llt_addr_o, llt_data_o);
      end else begin
        ew = exp_wr.pop_front();
        if ({llt_addr_o, llt_data_o} !== ew) begin
          n_errors++;
          $display("FAIL llt_write: got %h/%h, expected %h/%h", llt_addr_o, llt_data_o, ew[34:32], ew[31:0]);
        end
      end
    end
    if (done_o) done_cnt++;
  end

  task automatic pulse_phase(input logic [7:0] p);
    @(posedge clock_i); #1;
    phase_change_i = 1'b1;
    phase_i        = p;
    @(posedge clock_i); #1;
    phase_change_i = 1'b0;
  endtask

  task automatic wait_done(input int target, output bit ok);
    int k;
    k = 0;
    while (done_cnt < target && k < 2000) begin
      @(negedge clock_i);
      k++;
    end
    ok = (done_cnt >= target);
    repeat (3) @(negedge clock_i);
  endtask

  task automatic test_reset;
    repeat (3) @(negedge clock_i);
    n_checks++;
    if ({busy_o, done_o, mem_req_o, llt_wren_o, overflow_o} !== 5'b0) begin
      n_errors++;
      $display("FAIL reset_flags: got %b, expected 00000", {busy_o, done_o, mem_req_o, llt_wren_o, overflow_o});
    end
    n_checks++;
    if ({mem_addr_o, llt_addr_o, llt_data_o, phase_refs_o} !== 69'd0) begin
      n_errors++;
      $display("FAIL reset_buses: addr %h llt %h/%h refs %0d, expected all 0", mem_addr_o, llt_addr_o, llt_data_o, phase_refs_o);
    end
`ifdef LEASE_LOADER_STATS_EN
    n_checks++;
    if (load_cycles_o !== 32'd0) begin
      n_errors++;
      $display("FAIL reset_load_cycles: got %0d, expected 0", load_cycles_o);
    end
`endif
    @(posedge clock_i); #1;
    resetn_i = 1'b1;
    repeat (2) @(negedge clock_i);
    n_checks++;
    if (busy_o !== 1'b0) begin
      n_errors++;
      $display("FAIL idle_after_reset: busy %b, expected 0", busy_o);
    end
  endtask

  task automatic run_load(input int p, input string name, input int exp_refs, input int exp_lse, input bit exp_ovf);
    int  d0, r0, l0;
    bit  ok;
    d0 = done_cnt; r0 = ref_wr; l0 = lse_wr;
    expect_load(p);
    pulse_phase(8'(p));
    wait_done(d0 + 1, ok);
    n_checks++;
    if (!ok || done_cnt - d0 != 1) begin
      n_errors++;
      $display("FAIL %s_done: pulses %0d, expected 1", name, done_cnt - d0);
    end
    n_checks++;
    if (ref_wr - r0 != N || lse_wr - l0 != exp_lse) begin
      n_errors++;
      $display("FAIL %s_writes: ref %0d lease %0d, expected %0d %0d", name, ref_wr - r0, lse_wr - l0, N, exp_lse);
    end
    n_checks++;
    if (phase_refs_o !== 2'(exp_refs) || overflow_o !== exp_ovf) begin
      n_errors++;
      $display("FAIL %s_refs: refs %0d ovf %b, expected %0d %b", name, phase_refs_o, overflow_o, exp_refs, exp_ovf);
    end
    n_checks++;
    if (exp_rd.size() != 0 || exp_wr.size() != 0 || busy_o !== 1'b0) begin
      n_errors++;
      $display("FAIL %s_drain: reads left %0d writes left %0d busy %b, expected 0 0 0", name, exp_rd.size(), exp_wr.size(), busy_o);
    end
  endtask

  task automatic test_basic;
    hdr[blk(1)] = 32'd2;
    run_load(1, "basic", 2, 2, 1'b0);
`ifdef LEASE_LOADER_STATS_EN
    n_checks++;
    if (load_cycles_o !== 32'(4 * (1 + N + 2))) begin
      n_errors++;
      $display("FAIL load_cycles: got %0d, expected %0d", load_cycles_o, 4 * (1 + N + 2));
    end
`endif
  endtask

  task automatic test_zero_count;
    hdr[blk(3)] = 32'd0;
    run_load(3, "zero", 0, 0, 1'b0);
  endtask

  task automatic test_overflow;
    hdr[blk(4)] = 32'd9;
    run_load(4, "overflow", 3, 3, 1'b1);
    run_load(1, "sticky", 2, 2, 1'b1);
  endtask

  task automatic test_back_to_back;
    int d0;
    bit ok;
    hdr[blk(0)] = 32'd1;
    hdr[blk(2)] = 32'd2;
    hdr[blk(5)] = 32'd3;
    d0 = done_cnt;
    expect_load(0);
    expect_load(5);
    pulse_phase(8'd0);
    repeat (2) @(posedge clock_i);
    pulse_phase(8'd2);
    repeat (3) @(posedge clock_i);
    pulse_phase(8'd5);
    wait_done(d0 + 2, ok);
    repeat (10) @(negedge clock_i);
    n_checks++;
    if (done_cnt - d0 != 2) begin
      n_errors++;
      $display("FAIL b2b_done: pulses %0d, expected 2", done_cnt - d0);
    end
    n_checks++;
    if (phase_refs_o !== 2'd3 || exp_rd.size() != 0 || exp_wr.size() != 0) begin
      n_errors++;
      $display("FAIL b2b_phase5: refs %0d reads left %0d writes left %0d, expected 3 0 0", phase_refs_o, exp_rd.size(), exp_wr.size());
    end
  endtask

  task automatic test_reset_midload;
    int  k, w0;
    bit  seen;
    logic [31:0] b;
    b = blk(6);
    hdr[b] = 32'd2;
    exp_rd.push_back(b);
    exp_rd.push_back(b + 32'd4);
    pulse_phase(8'd6);
    k = 0; seen = 1'b0;
    while (!seen && k < 200) begin
      @(negedge clock_i);
      seen = mem_req_o && (mem_addr_o == b + 32'd4);
      k++;
    end
    n_checks++;
    if (!seen) begin
      n_errors++;
      $display("FAIL midload_ref_req: first ref read not seen, expected at %h", b + 32'd4);
    end
    @(posedge clock_i); #1;
    resetn_i = 1'b0;
    w0 = ref_wr + lse_wr;
    @(negedge clock_i);
    n_checks++;
    if ({busy_o, mem_req_o, llt_wren_o, overflow_o, phase_refs_o} !== 6'd0) begin
      n_errors++;
      $display("FAIL midload_reset_outputs: got %b, expected 000000", {busy_o, mem_req_o, llt_wren_o, overflow_o, phase_refs_o});
    end
    @(posedge clock_i); #1;
    resetn_i = 1'b1;
    repeat (8) @(negedge clock_i);
    n_checks++;
    if (ref_wr + lse_wr != w0 || busy_o !== 1'b0 || exp_rd.size() != 0) begin
      n_errors++;
      $display("FAIL late_ack: writes %0d busy %b reads left %0d, expected 0 0 0", ref_wr + lse_wr - w0, busy_o, exp_rd.size());
    end
    run_load(1, "recover", 2, 2, 1'b0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_basic();
    test_zero_count();
    test_overflow();
    test_back_to_back();
    test_reset_midload();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/lease_table_loader.md
LEASE_TABLE_LOADER -- requirements
Module: lease_table_loader

Interface
REQ-001 SHALL have parameter N_ENTRIES, default 128: LLT entries per table, a power of two.
REQ-002 SHALL have parameter BW_PHASE, default 8: phase index width.
REQ-003 SHALL have local BW_ENTRIES = CLOG2(N_ENTRIES) and PHASE_STRIDE = 2*N_ENTRIES+1 words.
REQ-004 clock_i  in  1  the single clock.
REQ-005 resetn_i  in  1  reset, asynchronous and active-low.
REQ-006 phase_change_i  in  1  one-cycle pulse requesting a table load.
REQ-007 phase_i  in  BW_PHASE  target phase, sampled with phase_change_i.
REQ-008 base_addr_i  in  32  byte address of the phase-0 lease block, word aligned, held static.
REQ-009 mem_req_o / mem_addr_o  out  1 / 32  word read request and its byte address.
REQ-010 mem_ack_i / mem_data_i  in  1 / 32  read completion and its data word.
REQ-011 llt_addr_o  out  BW_ENTRIES+1  table write address: MSB 0 selects ref array, MSB 1 selects lease array.
REQ-012 llt_wren_o / llt_data_o  out  1 / 32  table write strobe and write word.
REQ-013 phase_refs_o  out  BW_ENTRIES  valid-reference count for the loaded phase.
REQ-014 busy_o / done_o / overflow_o  out  1 each  load active / one-cycle load-complete pulse / sticky count-saturated flag.

Function
REQ-015 Memory layout SHALL be: block at base_addr_i + 4*PHASE_STRIDE*phase; word 0 = ref count; words 1..N_ENTRIES = ref byte addresses; words N_ENTRIES+1..2*N_ENTRIES = leases.
REQ-016 FSM states SHALL be IDLE, HDR_REQ, HDR_WAIT, REF_REQ, REF_WAIT, LSE_REQ, LSE_WAIT, DONE.
REQ-017 IDLE->HDR_REQ on phase_change_i or on a pending request; the block base address is computed and latched on this transition.
REQ-018 Each *_REQ state SHALL assert mem_req_o for exactly one cycle and then enter the matching *_WAIT; mem_addr_o SHALL stay stable until mem_ack_i; at most one read SHALL be outstanding.
REQ-019 HDR_WAIT on ack SHALL latch the count into phase_refs_o, saturating at N_ENTRIES-1 and setting overflow_o when it saturates, then enter REF_REQ with index 0.
REQ-020 REF_WAIT on ack SHALL pulse llt_wren_o with llt_addr_o={0,idx} and llt_data_o=mem_data_i in the same cycle as the ack; after idx=N_ENTRIES-1 it SHALL enter LSE_REQ, otherwise REF_REQ with idx+1.
REQ-021 All N_ENTRIES ref slots SHALL be written on every load, so stale valid bits are cleared.
REQ-022 LSE_WAIT SHALL write {1,idx} likewise; only idx < phase_refs_o SHALL be fetched, and a count of 0 SHALL skip straight to DONE.
REQ-023 phase_refs_o SHALL be stable from the header ack until the next header ack.
REQ-024 DONE SHALL pulse done_o for one cycle and return to IDLE.
REQ-025 busy_o SHALL be high in every state except IDLE; it is combinational from state.
REQ-026 phase_change_i while busy SHALL set a single pending flag and capture phase_i; the newest request overwrites any earlier one; the pending load starts on the cycle after DONE.
REQ-027 phase_change_i in IDLE with pending set is impossible by construction; phase_change_i in DONE SHALL be treated as pending.
REQ-028 mem_ack_i outside a *_WAIT state SHALL be ignored.
REQ-029 Index and address arithmetic SHALL be unsigned 32-bit, with wrap-around modulo 2^32 not flagged.

Reset
REQ-030 Assertion of resetn_i SHALL immediately force: state IDLE, all outputs 0, phase_refs_o 0, overflow_o 0, pending cleared, index 0.
REQ-031 Reset mid-load SHALL abandon the load; a late mem_ack_i after reset SHALL be ignored.

Configuration
REQ-032 Macro LEASE_LOADER_STATS_EN SHALL, when defined, add output load_cycles_o [31:0]: cycles from HDR_REQ entry to DONE of the last load, updated at DONE and reset to 0.
REQ-033 Without LEASE_LOADER_STATS_EN, the port and counter SHALL be absent.

Structure
REQ-034 The FSM state enum and the PHASE_STRIDE function SHALL reside in the shared package lease_cache_pkg.
REQ-035 Block-base address computation SHALL be the sub-module lease_loader_addr_gen (registered output); all else is inline.

Verification
REQ-036 N_ENTRIES=4, base=0x1000, phase=1, count=2 -> reads 0x1024, 0x1028..0x1034, 0x1038, 0x103C; 4 ref writes, 2 lease writes; phase_refs_o=2; one done_o pulse.
REQ-037 count=0 -> 4 ref writes, no lease reads, done_o pulses; phase_refs_o=0.
REQ-038 count=9 with N_ENTRIES=4 -> phase_refs_o=3, overflow_o=1 sticky, 3 lease writes.
REQ-039 two phase_change_i pulses (phases 2 then 5) during a load -> exactly one further load, for phase 5, starting after done_o.
REQ-040 resetn_i low during REF_WAIT, then ack -> no llt_wren_o, state IDLE, outputs 0; with stats enabled, load_cycles_o is the exact cycle count under a 3-cycle ack latency.
